// File: rtl/srl_delay_cal.sv
// Round-trip latency calibrator: launches one marker, counts clocks until it
// returns, then picks the SRL16E tap that pads the loop up to the target latency.
module srl_delay_cal #(
  parameter int         MXCNT   = 6,
  parameter int         TIMEOUT = 48,
  parameter logic [3:0] ADR_RST = 4'd0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [MXCNT-1:0] target,
  output logic             marker_tx,
  input  logic             marker_rx,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic             err_range,
  output logic [MXCNT-1:0] meas,
  output logic [3:0]       adr,
  output logic             adr_ce
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_WAIT = 3'd2,
    ST_CALC = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  localparam logic [MXCNT-1:0]        TIMEOUT_C = MXCNT'(TIMEOUT);
  localparam logic [MXCNT-1:0]        ONE_C     = MXCNT'(1);
  localparam logic [MXCNT-1:0]        ZERO_C    = {MXCNT{1'b0}};
  localparam logic signed [MXCNT:0]   PAD_ONE   = (MXCNT+1)'(1);
  localparam logic signed [MXCNT:0]   PAD_MAX   = (MXCNT+1)'(15);

  // Clamp the signed pad into the 4-bit tap range; MSB flags an out-of-range pad.
  function automatic logic [4:0] clamp_tap(input logic signed [MXCNT:0] pad);
    logic [4:0] res;
    if (pad[MXCNT]) begin
      res = {1'b1, 4'd0};
    end else if (pad > PAD_MAX) begin
      res = {1'b1, 4'd15};
    end else begin
      res = {1'b0, pad[3:0]};
    end
    return res;
  endfunction

  state_t                state_r, next_state_s;
  logic [MXCNT-1:0]      cnt_r, cnt_nxt_s;
  logic [MXCNT-1:0]      tgt_r, tgt_nxt_s;
  logic [MXCNT-1:0]      meas_r, meas_nxt_s;
  logic [3:0]            adr_r, adr_nxt_s;
  logic                  err_range_r, err_range_nxt_s;
  logic                  adr_ce_r, adr_ce_nxt_s;
  logic                  marker_tx_r, busy_r, done_r, err_timeout_r;
  logic signed [MXCNT:0] pad_s;
  logic [4:0]            tap_s;

  assign pad_s = $signed({1'b0, tgt_r}) - $signed({1'b0, meas_r}) - PAD_ONE;
  assign tap_s = clamp_tap(pad_s);

  // Next-state and next-value logic for the calibration sequence.
  always_comb begin
    next_state_s    = state_r;
    cnt_nxt_s       = cnt_r;
    tgt_nxt_s       = tgt_r;
    meas_nxt_s      = meas_r;
    adr_nxt_s       = adr_r;
    err_range_nxt_s = err_range_r;
    adr_ce_nxt_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          next_state_s    = ST_SEND;
          tgt_nxt_s       = target;
          meas_nxt_s      = ZERO_C;
          err_range_nxt_s = 1'b0;
        end else begin
          next_state_s = state_r;
        end
      end
      ST_SEND: begin
        cnt_nxt_s    = ONE_C;
        next_state_s = ST_WAIT;
      end
      ST_WAIT: begin
        // A returning marker wins over the timeout on the same cycle.
        if (marker_rx) begin
          meas_nxt_s   = cnt_r;
          next_state_s = ST_CALC;
        end else if (cnt_r == TIMEOUT_C) begin
          next_state_s = ST_ERR;
        end else begin
          cnt_nxt_s = cnt_r + ONE_C;
        end
      end
      ST_CALC: begin
        adr_nxt_s       = tap_s[3:0];
        err_range_nxt_s = tap_s[4];
        adr_ce_nxt_s    = (tap_s[3:0] != adr_r);
        next_state_s    = ST_DONE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      cnt_r         <= ZERO_C;
      tgt_r         <= ZERO_C;
      meas_r        <= ZERO_C;
      adr_r         <= ADR_RST;
      err_range_r   <= 1'b0;
      adr_ce_r      <= 1'b0;
      marker_tx_r   <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      cnt_r         <= cnt_nxt_s;
      tgt_r         <= tgt_nxt_s;
      meas_r        <= meas_nxt_s;
      adr_r         <= adr_nxt_s;
      err_range_r   <= err_range_nxt_s;
      adr_ce_r      <= adr_ce_nxt_s;
      // Status flags track the state being entered so they line up with it.
      marker_tx_r   <= (next_state_s == ST_SEND);
      busy_r        <= (next_state_s == ST_SEND) || (next_state_s == ST_WAIT) ||
                       (next_state_s == ST_CALC);
      done_r        <= (next_state_s == ST_DONE);
      err_timeout_r <= (next_state_s == ST_ERR);
    end
  end

  assign marker_tx   = marker_tx_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign err_timeout = err_timeout_r;
  assign err_range   = err_range_r;
  assign meas        = meas_r;
  assign adr         = adr_r;
  assign adr_ce      = adr_ce_r;

endmodule

// File: tb/tb_srl_delay_cal.sv
// Scoreboard bench for srl_delay_cal: directed calibrations push expected
// results, a negedge monitor checks them when done or err_timeout rises.
module tb_srl_delay_cal;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic [5:0] target;
  logic       marker_tx;
  logic       marker_rx;
  logic       busy, done, err_timeout, err_range, adr_ce;
  logic [5:0] meas;
  logic [3:0] adr;

  srl_delay_cal #(.MXCNT(6), .TIMEOUT(48), .ADR_RST(4'd0)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .target(target),
    .marker_tx(marker_tx), .marker_rx(marker_rx), .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_range(err_range), .meas(meas),
    .adr(adr), .adr_ce(adr_ce)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       done;
    logic       errto;
    logic       erng;
    logic [5:0] meas;
    logic [3:0] adr;
    logic       ce;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   failed = 0;
  int   cyc = 0;
  int   tx_cnt = 0;
  int   tx_cyc = 0;
  int   ce_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic d, input logic et, input logic er,
                              input int m, input int a, input logic c, input int l);
    exp_t e;
    e.done = d; e.errto = et; e.erng = er;
    e.meas = 6'(m); e.adr = 4'(a); e.ce = c; e.lat = l;
    return e;
  endfunction

  // Monitor: counts marker/adr_ce pulses and scores each completion event
  initial begin
    logic done_q, errto_q;
    exp_t e;
    done_q = 1'b0;
    errto_q = 1'b0;
    forever begin
      @(negedge clock);
      if (marker_tx === 1'b1) begin
        tx_cnt++;
        tx_cyc = cyc;
      end
      if (adr_ce === 1'b1) ce_cnt++;
      if ((done === 1'b1 && !done_q) || (err_timeout === 1'b1 && !errto_q)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("ev_done", int'(done), int'(e.done));
          check("ev_err_timeout", int'(err_timeout), int'(e.errto));
          check("ev_err_range", int'(err_range), int'(e.erng));
          check("ev_meas", int'(meas), int'(e.meas));
          check("ev_adr", int'(adr), int'(e.adr));
          check("ev_adr_ce", int'(adr_ce), int'(e.ce));
          check("ev_latency", cyc - tx_cyc, e.lat);
        end
      end
      done_q = (done === 1'b1);
      errto_q = (err_timeout === 1'b1);
    end
  end

  task automatic wait_event();
    for (int i = 0; i < 120; i++) begin
      if (done === 1'b1 || err_timeout === 1'b1) break;
      @(posedge clock); #1;
    end
    check("event_wait", int'(done | err_timeout), 1);
  endtask

  // k = 0 means the marker never comes back
  task automatic run_cal(input int t, input int k, input exp_t e);
    exp_q.push_back(e);
    @(posedge clock); #1;
    start = 1'b1;
    target = 6'(t);
    @(posedge clock); #1;
    start = 1'b0;
    if (k > 0) begin
      repeat (k) @(posedge clock);
      #1 marker_rx = 1'b1;
      @(posedge clock); #1;
      marker_rx = 1'b0;
    end
    wait_event();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_marker_tx"}, int'(marker_tx), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_err_timeout"}, int'(err_timeout), 0);
    check({tag, "_err_range"}, int'(err_range), 0);
    check({tag, "_meas"}, int'(meas), 0);
    check({tag, "_adr"}, int'(adr), 0);
    check({tag, "_adr_ce"}, int'(adr_ce), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tx0;
    reset_n = 1'b0;
    start = 1'b0;
    target = 6'd0;
    marker_rx = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_values("reset");
    reset_n = 1'b1;
    @(posedge clock); #1;

    // nominal: pad = 12-5-1 = 6
    run_cal(12, 5, mk(1'b1, 1'b0, 1'b0, 5, 6, 1'b1, 7));
    // pad = -1 -> clamp to 0
    run_cal(4, 4, mk(1'b1, 1'b0, 1'b1, 4, 0, 1'b1, 6));
    // pad = 36 -> clamp to 15
    run_cal(40, 3, mk(1'b1, 1'b0, 1'b1, 3, 15, 1'b1, 5));
    // no return: timeout TIMEOUT+1 cycles after the marker, adr held
    run_cal(20, 0, mk(1'b0, 1'b1, 1'b0, 0, 15, 1'b0, 49));
    check("timeout_busy", int'(busy), 0);
    check("timeout_done", int'(done), 0);
    // restart out of ERR
    run_cal(12, 5, mk(1'b1, 1'b0, 1'b0, 5, 6, 1'b1, 7));
    check("restart_err_timeout", int'(err_timeout), 0);

    // start during WAIT is ignored, then reset aborts the run
    tx0 = tx_cnt;
    @(posedge clock); #1;
    start = 1'b1;
    target = 6'd10;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("single_marker", tx_cnt - tx0, 1);
    check("wait_busy", int'(busy), 1);
    reset_n = 1'b0;
    @(posedge clock); #1;
    check_reset_values("midreset");
    reset_n = 1'b1;
    marker_rx = 1'b1;
    @(posedge clock); #1;
    marker_rx = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check_reset_values("late_rx");

    // identical back-to-back runs: second one leaves adr alone, no strobe
    run_cal(12, 5, mk(1'b1, 1'b0, 1'b0, 5, 6, 1'b1, 7));
    run_cal(12, 5, mk(1'b1, 1'b0, 1'b0, 5, 6, 1'b0, 7));
    // marker on the TIMEOUT cycle is accepted: pad = 60-48-1 = 11
    run_cal(60, 48, mk(1'b1, 1'b0, 1'b0, 48, 11, 1'b1, 50));

    repeat (3) @(posedge clock);
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("adr_ce_total", ce_cnt, 6);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
